// File: rtl/cmp_zelg_serial.sv
// Bit-serial MSB-first magnitude comparator producing zero/equal/less/greater flags.
// Optional macro CMP_ZELG_SERIAL_EARLY_EXIT_EN ends the operation at the first differing bit.
module cmp_zelg_serial #(
    parameter int p_WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [p_WIDTH-1:0] iv_x,
    input  logic [p_WIDTH-1:0] iv_y,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_zero,
    output logic               o_equal,
    output logic               o_less,
    output logic               o_greater
);

    localparam int CW = (p_WIDTH > 1) ? $clog2(p_WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state_reg;
    logic [p_WIDTH-1:0] x_reg;
    logic [p_WIDTH-1:0] y_reg;
    logic [CW-1:0]      cnt_reg;
    logic               decided_reg;
    logic               less_reg;
    logic               zero_reg;

    logic bit_x;
    logic bit_y;
    logic diff;
    logic decided_next;
    logic less_next;
    logic zero_next;
    logic finish;

    // Decision for the bit currently at the MSB of the shift registers.
    always_comb begin
        bit_x        = x_reg[p_WIDTH-1];
        bit_y        = y_reg[p_WIDTH-1];
        diff         = bit_x ^ bit_y;
        decided_next = decided_reg | diff;
        less_next    = decided_reg ? less_reg : (~bit_x & bit_y);
        zero_next    = zero_reg & ~bit_x;
`ifdef CMP_ZELG_SERIAL_EARLY_EXIT_EN
        finish       = (cnt_reg == '0) || (diff && !decided_reg);
`else
        finish       = (cnt_reg == '0);
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= ST_IDLE;
            x_reg       <= '0;
            y_reg       <= '0;
            cnt_reg     <= '0;
            decided_reg <= 1'b0;
            less_reg    <= 1'b0;
            zero_reg    <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_zero      <= 1'b0;
            o_equal     <= 1'b0;
            o_less      <= 1'b0;
            o_greater   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        state_reg   <= ST_RUN;
                        x_reg       <= iv_x;
                        y_reg       <= iv_y;
                        cnt_reg     <= CW'(p_WIDTH - 1);
                        decided_reg <= 1'b0;
                        less_reg    <= 1'b0;
                        zero_reg    <= 1'b1;
                        o_busy      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    x_reg       <= x_reg << 1;
                    y_reg       <= y_reg << 1;
                    cnt_reg     <= cnt_reg - CW'(1);
                    decided_reg <= decided_next;
                    less_reg    <= less_next;
                    zero_reg    <= zero_next;
                    if (finish) begin
                        // Flags change only here, on the edge entering DONE.
                        state_reg <= ST_DONE;
                        o_busy    <= 1'b0;
                        o_done    <= 1'b1;
                        o_equal   <= ~decided_next;
                        o_zero    <= ~decided_next & zero_next;
                        o_less    <= decided_next & less_next;
                        o_greater <= decided_next & ~less_next;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    o_done    <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    o_busy    <= 1'b0;
                    o_done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_zelg_serial.sv
// Directed bench for cmp_zelg_serial: 4-bit scenarios plus exhaustive 1- and 2-bit sweeps.
module tb_cmp_zelg_serial;

`ifdef CMP_ZELG_SERIAL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start4 = 0, start1 = 0, start2 = 0;
    logic [3:0] x4 = 0, y4 = 0;
    logic [0:0] x1 = 0, y1 = 0;
    logic [1:0] x2 = 0, y2 = 0;
    logic busy4, done4, zero4, equal4, less4, greater4;
    logic busy1, done1, zero1, equal1, less1, greater1;
    logic busy2, done2, zero2, equal2, less2, greater2;

    int tests = 0;
    int fails = 0;

    cmp_zelg_serial #(.p_WIDTH(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(start4), .iv_x(x4), .iv_y(y4),
        .o_busy(busy4), .o_done(done4), .o_zero(zero4), .o_equal(equal4),
        .o_less(less4), .o_greater(greater4)
    );
    cmp_zelg_serial #(.p_WIDTH(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .iv_x(x1), .iv_y(y1),
        .o_busy(busy1), .o_done(done1), .o_zero(zero1), .o_equal(equal1),
        .o_less(less1), .o_greater(greater1)
    );
    cmp_zelg_serial #(.p_WIDTH(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .iv_x(x2), .iv_y(y2),
        .o_busy(busy2), .o_done(done2), .o_zero(zero2), .o_equal(equal2),
        .o_less(less2), .o_greater(greater2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference flags {zero, equal, less, greater} straight from the operand values.
    function automatic logic [3:0] ref_flags(input int x, input int y);
        return {(x == 0) && (x == y), x == y, x < y, x > y};
    endfunction

    function automatic int ref_lat(input int x, input int y, input int w);
        if (EARLY)
            for (int i = w - 1; i >= 0; i--)
                if (((x >> i) & 1) != ((y >> i) & 1)) return w - i;
        return w;
    endfunction

    function automatic logic [3:0] flags4();
        return {zero4, equal4, less4, greater4};
    endfunction

    task automatic cmp4(input string tag, input int x, input int y);
        int k;
        x4 = 4'(x); y4 = 4'(y); start4 = 1;
        tick();
        start4 = 0;
        check({tag, "_busy"}, busy4, 1);
        k = 0;
        while (!done4 && k < 40) begin
            tick();
            k++;
        end
        check({tag, "_lat"}, k, ref_lat(x, y, 4));
        check({tag, "_flags"}, flags4(), ref_flags(x, y));
        tick();
        check({tag, "_pulse"}, done4, 0);
        $display("[TB] %s x=%0d y=%0d lat=%0d flags=%b", tag, x, y, k, flags4());
    endtask

    initial begin
        #1;
        check("reset_outs", {busy4, done4, flags4()}, 6'b0);
        repeat (2) tick();
        rst = 0;
        tick();

        cmp4("t1_gt", 5, 3);
        cmp4("t2_lt", 3, 5);
        cmp4("t2_zero", 0, 0);
        cmp4("t3_eq", 9, 9);
        repeat (5) tick();
        check("t3_hold", flags4(), 4'b0100);
        cmp4("t4_msb", 8, 0);
        cmp4("t4_lsb", 6, 7);

        // Reset two edges into RUN discards the operation immediately.
        x4 = 12; y4 = 3; start4 = 1;
        tick();
        start4 = 0;
        repeat (2) tick();
        rst = 1;
        #1;
        check("t5_rst", {busy4, done4, flags4()}, 6'b0);
        $display("[TB] t5 reset mid-run outs=%b", {busy4, done4, flags4()});
        tick();
        rst = 0;
        tick();
        cmp4("t5_after", 12, 3);

        // Start during RUN is ignored; flags hold during RUN.
        begin
            int k;
            cmp4("t6_prev", 2, 11);
            x4 = 5; y4 = 3; start4 = 1;
            tick();
            x4 = 1; y4 = 14;
            tick();
            check("t6_holdrun", flags4(), 4'b0010);
            start4 = 0;
            k = 1;
            while (!done4 && k < 40) begin
                tick();
                k++;
            end
            check("t6_lat", k, ref_lat(5, 3, 4));
            check("t6_flags", flags4(), 4'b0001);
            // Start coincident with done is dropped, the next one is taken.
            start4 = 1;
            tick();
            check("t6_drop", busy4, 0);
            tick();
            start4 = 0;
            check("t6_accept", busy4, 1);
            $display("[TB] t6 ignored start, flags=%b", flags4());
            repeat (8) tick();
            check("t6_res", flags4(), ref_flags(1, 14));
        end

        // Exhaustive 1-bit sweep.
        for (int x = 0; x < 2; x++) begin
            for (int y = 0; y < 2; y++) begin
                int k;
                x1 = 1'(x); y1 = 1'(y); start1 = 1;
                tick();
                start1 = 0;
                k = 0;
                while (!done1 && k < 20) begin tick(); k++; end
                check("w1_lat", k, 1);
                check("w1_flags", {zero1, equal1, less1, greater1}, ref_flags(x, y));
                $display("[TB] w1 x=%0d y=%0d flags=%b", x, y, {zero1, equal1, less1, greater1});
                tick();
            end
        end

        // Exhaustive 2-bit sweep.
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                int k;
                x2 = 2'(x); y2 = 2'(y); start2 = 1;
                tick();
                start2 = 0;
                k = 0;
                while (!done2 && k < 20) begin tick(); k++; end
                check("w2_lat", k, ref_lat(x, y, 2));
                check("w2_flags", {zero2, equal2, less2, greater2}, ref_flags(x, y));
                $display("[TB] w2 x=%0d y=%0d flags=%b", x, y, {zero2, equal2, less2, greater2});
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
